// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_if: bundles the BCD digit inputs, the blink request and the display
// pins of the 4-digit seven-segment scan driver.
//   min_tens/min_ones/sec_tens/sec_ones : BCD digits (MM:SS) from the counter
//   blink[1:0] : bit1 blinks the minutes pair, bit0 the seconds pair
//   seg[7:0]   : active-low segments, seg[7]=dp, seg[6:0]=g..a
//   an[3:0]    : active-low digit enables
// master: the side supplying the digits and watching the pins.
// slave : the scan driver.
// ---------------------------------------------------------------------------
interface seg7_if;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic [1:0] blink;
   logic [7:0] seg;
   logic [3:0] an;

   modport master (
      output min_tens, min_ones, sec_tens, sec_ones, blink,
      input  seg, an
   );

   modport slave (
      input  min_tens, min_ones, sec_tens, sec_ones, blink,
      output seg, an
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display.
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : seg7_if.slave (digit inputs, blink request, seg/an pins)
// Parameters:
//   SCAN_DIV  : clock cycles per digit slot (>= 2)
//   BLINK_DIV : clock cycles per blink half-period (>= 1)
// Optional build macro:
//   SEG7_DP_EN : when defined, dp is lit on the visible digit-2 slot (MM.SS)
// Each slot starts with one blank cycle to suppress ghosting. The four digits
// are shadowed once per frame so a frame never mixes old and new values.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input logic   clk,
   input logic   rst,
   seg7_if.slave bus
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [3:0]    shadow [4];
   logic [BW-1:0] blk_cnt;
   logic          phase;      // 1 = hidden half of the blink period
   logic [7:0]    seg_q;
   logic [3:0]    an_q;

   logic [7:0]    seg_d;
   logic [3:0]    an_d;
   logic          slot_blank;
   logic          cnt_wrap;
   logic          capture;
   logic          blink_on;
   logic          blk_wrap;
   logic          dp_n;

   // Active-low g..a pattern; codes above 9 show a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h40;
         4'd1:    p = 7'h79;
         4'd2:    p = 7'h24;
         4'd3:    p = 7'h30;
         4'd4:    p = 7'h19;
         4'd5:    p = 7'h12;
         4'd6:    p = 7'h02;
         4'd7:    p = 7'h78;
         4'd8:    p = 7'h00;
         4'd9:    p = 7'h10;
         default: p = 7'h3F;
      endcase
      return p;
   endfunction

   always_comb begin
      cnt_wrap = (cnt == CNT_LAST);
      capture  = cnt_wrap && (idx == 2'd3);
      blink_on = |bus.blink;
      blk_wrap = (blk_cnt == BLK_LAST);
      // idx[1] selects the pair: digits 3,2 -> blink[1], digits 1,0 -> blink[0].
      // blink is used live so clearing it un-hides on the very next output.
      slot_blank = (cnt == '0) || (phase && bus.blink[idx[1]]);
`ifdef SEG7_DP_EN
      dp_n = (idx != 2'd2);
`else
      dp_n = 1'b1;
`endif
      seg_d = 8'hFF;
      an_d  = 4'hF;
      if (!slot_blank) begin
         an_d  = ~(4'b0001 << idx);
         seg_d = {dp_n, decode(shadow[idx])};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= 2'd0;
         blk_cnt <= '0;
         phase   <= 1'b0;
         seg_q   <= 8'hFF;
         an_q    <= 4'hF;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= 4'd0;
         end
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;

         if (cnt_wrap) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end

         if (capture) begin
            shadow[0] <= bus.sec_ones;
            shadow[1] <= bus.sec_tens;
            shadow[2] <= bus.min_ones;
            shadow[3] <= bus.min_tens;
         end

         if (!blink_on) begin
            blk_cnt <= '0;
            phase   <= 1'b0;
         end else if (blk_wrap) begin
            blk_cnt <= '0;
            phase   <= ~phase;
         end else begin
            blk_cnt <= blk_cnt + BW'(1);
         end
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;

endmodule
